// File: rtl/conunit_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit:
// instruction encodings, state codes, ALU and PC-source codes.
package conunit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_XOR = 6'b100110;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EXE = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_ILL
    } kind_t;

    typedef struct packed {
        kind_t kind;
        logic  aluqb;
        logic  se;
        logic  regrt;
    } dec_t;

endpackage

// File: rtl/conunit_dec.sv
// Pure combinational instruction decode: classifies Op/Func and produces the
// datapath selects and ALU code for the instruction held in the IR.
import conunit_pkg::*;

module conunit_dec #(
    parameter int ALUC_W  = 2,
    parameter int EXT_OPS = 0
) (
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    output dec_t              dec,
    output logic [ALUC_W-1:0] aluc
);

    localparam bit XEN = (EXT_OPS != 0) && (ALUC_W >= 3);

    always_comb begin
        dec  = '{kind: K_ILL, aluqb: 1'b0, se: 1'b0, regrt: 1'b0};
        aluc = ALUC_W'(ALU_ADD);
        case (op)
            OP_RTYPE: begin
                dec.aluqb = 1'b1;
                case (func)
                    FUNC_ADD: begin dec.kind = K_ALU; aluc = ALUC_W'(ALU_ADD); end
                    FUNC_SUB: begin dec.kind = K_ALU; aluc = ALUC_W'(ALU_SUB); end
                    FUNC_AND: begin dec.kind = K_ALU; aluc = ALUC_W'(ALU_AND); end
                    FUNC_OR:  begin dec.kind = K_ALU; aluc = ALUC_W'(ALU_OR);  end
                    FUNC_XOR: if (XEN) begin dec.kind = K_ALU; aluc = ALUC_W'(ALU_XOR); end
                    default: ;
                endcase
            end
            // Immediate forms write rt; only addi sign-extends, logic ops zero-extend.
            OP_ADDI: begin dec.kind = K_ALU; dec.se = 1'b1; dec.regrt = 1'b1; aluc = ALUC_W'(ALU_ADD); end
            OP_ANDI: begin dec.kind = K_ALU; dec.regrt = 1'b1; aluc = ALUC_W'(ALU_AND); end
            OP_ORI:  begin dec.kind = K_ALU; dec.regrt = 1'b1; aluc = ALUC_W'(ALU_OR);  end
            OP_XORI: if (XEN) begin dec.kind = K_ALU; dec.regrt = 1'b1; aluc = ALUC_W'(ALU_XOR); end
            OP_LW:   begin dec.kind = K_LW; dec.se = 1'b1; dec.regrt = 1'b1; end
            OP_SW:   begin dec.kind = K_SW; dec.se = 1'b1; end
            OP_BEQ:  begin dec.kind = K_BEQ; dec.aluqb = 1'b1; dec.se = 1'b1; aluc = ALUC_W'(ALU_SUB); end
            OP_BNE:  begin dec.kind = K_BNE; dec.aluqb = 1'b1; dec.se = 1'b1; aluc = ALUC_W'(ALU_SUB); end
            OP_J:    dec.kind = K_J;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_conunit.sv
// Multi-cycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer with a memory
// wait counter that aborts a stalled access and reports it on Merr.
import conunit_pkg::*;

module mc_conunit #(
    parameter int ALUC_W      = 2,
    parameter int EXT_OPS     = 0,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic [5:0]        Op,
    input  logic [5:0]        Func,
    input  logic              Z,
    input  logic              Mrdy,
    output logic              Mreq,
    output logic              Wmem,
    output logic              Wreg,
    output logic              Wir,
    output logic              Wpc,
    output logic              Regrt,
    output logic              Se,
    output logic              Aluqb,
    output logic              Reg2reg,
    output logic [1:0]        Pcsrc,
    output logic [ALUC_W-1:0] Aluc,
    output logic [2:0]        State,
    output logic              Ill,
    output logic              Merr
);

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic       run;
    logic       waiting;
    logic       tmo;
    dec_t       dec;

    conunit_dec #(.ALUC_W(ALUC_W), .EXT_OPS(EXT_OPS)) u_dec (
        .op   (Op),
        .func (Func),
        .dec  (dec),
        .aluc (Aluc)
    );

    // run stays low until the first edge after reset release, so every
    // output is quiet while Clrn is low and for the remainder of that cycle.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state <= ST_IF;
            cnt   <= '0;
            run   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            run   <= 1'b1;
        end
    end

    assign waiting = (state == ST_IF) || (state == ST_MEM);
    // Mrdy in the timeout cycle still counts as a successful access.
    assign tmo     = run && waiting && (cnt == 8'(MEM_TIMEOUT)) && !Mrdy;

    always_comb begin
        state_d = ST_IF;
        Mreq    = 1'b0;
        Wmem    = 1'b0;
        Wreg    = 1'b0;
        Wir     = 1'b0;
        Wpc     = 1'b0;
        Ill     = 1'b0;
        Merr    = 1'b0;
        Pcsrc   = PC_SEQ;
        if (run) begin
            case (state)
                ST_IF: begin
                    Mreq = !tmo;
                    if (Mrdy) begin
                        Wir     = 1'b1;
                        Wpc     = 1'b1;
                        state_d = ST_ID;
                    end else if (tmo) begin
                        Merr = 1'b1;
                    end else begin
                        state_d = ST_IF;
                    end
                end
                ST_ID: begin
                    case (dec.kind)
                        K_J:     begin Wpc = 1'b1; Pcsrc = PC_JUMP; end
                        K_ILL:   Ill = 1'b1;
                        default: state_d = ST_EXE;
                    endcase
                end
                ST_EXE: begin
                    case (dec.kind)
                        K_BEQ:      begin Wpc = Z;  Pcsrc = PC_BRANCH; end
                        K_BNE:      begin Wpc = !Z; Pcsrc = PC_BRANCH; end
                        K_LW, K_SW: state_d = ST_MEM;
                        K_ALU:      state_d = ST_WB;
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    Mreq = !tmo;
                    Wmem = (dec.kind == K_SW) && !tmo;
                    if (Mrdy) begin
                        state_d = (dec.kind == K_LW) ? ST_WB : ST_IF;
                    end else if (tmo) begin
                        Merr = 1'b1;
                    end else begin
                        state_d = ST_MEM;
                    end
                end
                ST_WB:   Wreg = 1'b1;
                default: ;
            endcase
        end
        // Any entry into IF or MEM (including a timeout re-entry) restarts the count.
        if (!run || !waiting || tmo || (state_d != state)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt + 8'd1;
        end
    end

    assign Regrt   = dec.regrt;
    assign Se      = dec.se;
    assign Aluqb   = dec.aluqb;
    assign Reg2reg = (dec.kind != K_LW);
    assign State   = state;

endmodule

// File: tb/tb_mc_conunit.sv
// Self-checking bench for mc_conunit: an instruction-level model expands each
// instruction into its expected per-cycle trace, which the DUT is held against.
module tb_mc_conunit;

    localparam int T = 15;

    logic       Clk = 1'b0;
    logic       Clrn = 1'b0;
    logic [5:0] Op = '0;
    logic [5:0] Func = '0;
    logic       Z = 1'b0;
    logic       Mrdy = 1'b0;
    logic       Mreq, Wmem, Wreg, Wir, Wpc, Regrt, Se, Aluqb, Reg2reg, Ill, Merr;
    logic [1:0] Pcsrc;
    logic [1:0] Aluc;
    logic [2:0] State;

    mc_conunit #(.ALUC_W(2), .EXT_OPS(0), .MEM_TIMEOUT(T)) dut (
        .Clk(Clk), .Clrn(Clrn), .Op(Op), .Func(Func), .Z(Z), .Mrdy(Mrdy),
        .Mreq(Mreq), .Wmem(Wmem), .Wreg(Wreg), .Wir(Wir), .Wpc(Wpc),
        .Regrt(Regrt), .Se(Se), .Aluqb(Aluqb), .Reg2reg(Reg2reg),
        .Pcsrc(Pcsrc), .Aluc(Aluc), .State(State), .Ill(Ill), .Merr(Merr)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    // instruction classes: 0 alu, 1 lw, 2 sw, 3 beq, 4 bne, 5 j, 6 illegal
    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] func;
        int         cls;
        logic [1:0] alu;
        logic       qb;
        logic       se;
        logic       se_chk;
        logic       rt;
        logic       rt_chk;
    } ins_t;

    ins_t tbl[16];
    ins_t cur;
    logic cur_z;

    // scoreboard: {state, mreq, wmem, wreg, wir, wpc, ill, merr, pcsrc, aluc, aluqb, se, regrt, reg2reg}
    logic [17:0] exp_q[$];
    logic [17:0] msk_q[$];
    logic        mrdy_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    function automatic string st_name(input logic [2:0] s);
        case (s)
            3'd0: return "IF";
            3'd1: return "ID";
            3'd2: return "EXE";
            3'd3: return "MEM";
            3'd4: return "WB";
            default: return "??";
        endcase
    endfunction

    // en = {mreq, wmem, wreg, wir, wpc, ill, merr}
    function automatic void push(input logic [2:0] st, input logic [6:0] en, input logic [1:0] pcs,
                                 input logic mrdy, input logic sel, input logic r2r_chk,
                                 input logic r2r);
        exp_q.push_back({st, en, pcs, cur.alu, cur.qb, cur.se, cur.rt, r2r});
        msk_q.push_back({3'b111, 7'h7f, {2{en[2]}}, {2{sel}}, sel, sel & cur.se_chk,
                         sel & cur.rt_chk, r2r_chk});
        mrdy_q.push_back(mrdy);
    endfunction

    // One memory access of lat wait cycles; returns 1 when the access completes.
    function automatic bit access(input logic [2:0] st, input int lat, input logic fetch,
                                  input logic wr);
        for (int i = 0; i < lat && i < T; i++)
            push(st, {1'b1, wr, 5'b0}, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        if (lat <= T) begin
            push(st, {1'b1, wr, 1'b0, fetch, fetch, 2'b0}, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
            return 1'b1;
        end
        push(st, 7'b0000001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        return 1'b0;
    endfunction

    function automatic void build(input int if_lat, input int mem_lat);
        logic taken;
        if (!access(3'd0, if_lat, 1'b1, 1'b0)) return;
        if (cur.cls == 5) begin
            push(3'd1, 7'b0000100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        if (cur.cls == 6) begin
            push(3'd1, 7'b0000010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        push(3'd1, 7'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        if (cur.cls == 3 || cur.cls == 4) begin
            taken = (cur.cls == 3) ? cur_z : !cur_z;
            push(3'd2, {4'b0, taken, 2'b0}, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
            return;
        end
        push(3'd2, 7'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        if (cur.cls == 1 || cur.cls == 2) begin
            if (!access(3'd3, mem_lat, 1'b0, cur.cls == 2)) return;
            if (cur.cls == 2) return;
        end
        push(3'd4, 7'b0010000, 2'b00, 1'b0, 1'b0, 1'b1, cur.cls != 1);
    endfunction

    // driver + checker: stop_mem > 0 abandons the trace after that many MEM cycles
    task automatic run_queue(input int stop_mem);
        logic [17:0] e, m, obs;
        int mem_seen = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            @(posedge Clk);
            #1;
            Op = cur.op;
            Func = cur.func;
            Z = cur_z;
            Mrdy = mrdy_q.pop_front();
            @(negedge Clk);
            cyc++;
            obs = {State, Mreq, Wmem, Wreg, Wir, Wpc, Ill, Merr, Pcsrc, Aluc, Aluqb, Se,
                   Regrt, Reg2reg};
            tests++;
            assert ((obs & m) === (e & m)) else begin
                fails++;
                $error("FAIL %s/%s cyc=%0d observed=%h expected=%h", cur.name,
                       st_name(e[17:15]), cyc, obs & m, e & m);
            end
            if (stop_mem > 0 && e[17:15] == 3'd3) begin
                mem_seen++;
                if (mem_seen == stop_mem) begin
                    exp_q.delete();
                    msk_q.delete();
                    mrdy_q.delete();
                end
            end
        end
    endtask

    task automatic do_ins(input int idx, input logic z, input int if_lat, input int mem_lat);
        cur = tbl[idx];
        cur_z = z;
        build(if_lat, mem_lat);
        run_queue(0);
    endtask

    initial begin
        int r, lat_a, lat_b;
        tbl[0]  = '{"add",  6'h00, 6'h20, 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{"sub",  6'h00, 6'h22, 0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{"and",  6'h00, 6'h24, 0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{"or",   6'h00, 6'h25, 0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{"addi", 6'h08, 6'h15, 0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{"andi", 6'h0C, 6'h2A, 0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{"ori",  6'h0D, 6'h00, 0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{"lw",   6'h23, 6'h04, 1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{"sw",   6'h2B, 6'h08, 2, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{"beq",  6'h04, 6'h10, 3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{"bne",  6'h05, 6'h3C, 4, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{"j",    6'h02, 6'h01, 5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{"op3f", 6'h3F, 6'h00, 6, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{"xori", 6'h0E, 6'h00, 6, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{"xor",  6'h00, 6'h26, 6, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{"sll",  6'h00, 6'h00, 6, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        cur = tbl[0];
        cur_z = 1'b0;

        // reset state
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        tests++;
        assert ({State, Mreq, Wmem, Wreg, Wir, Wpc, Ill, Merr} === 10'b0) else begin
            fails++;
            $error("FAIL reset observed=%h expected=%h",
                   {State, Mreq, Wmem, Wreg, Wir, Wpc, Ill, Merr}, 10'b0);
        end
        Clrn = 1'b1;
        #1;
        tests++;
        assert (Mreq === 1'b0) else begin
            fails++;
            $error("FAIL mreq_before_first_edge observed=%b expected=0", Mreq);
        end

        // directed: lw with Mrdy after 2 cycles, branches, jump, illegal, timeouts
        do_ins(7, 1'b0, 2, 2);
        do_ins(9, 1'b1, 0, 0);
        do_ins(9, 1'b0, 0, 0);
        do_ins(10, 1'b0, 1, 0);
        do_ins(10, 1'b1, 0, 0);
        do_ins(11, 1'b0, 0, 0);
        do_ins(12, 1'b0, 0, 0);
        do_ins(0, 1'b0, T + 1, 0);
        do_ins(8, 1'b0, T, T + 1);
        do_ins(7, 1'b0, 0, T);
        do_ins(14, 1'b0, 0, 0);

        // reset asserted in the middle of a sw memory access
        cur = tbl[8];
        cur_z = 1'b0;
        build(0, 5);
        run_queue(2);
        #1;
        Clrn = 1'b0;
        #1;
        tests++;
        assert ({State, Mreq, Wmem} === 5'b0) else begin
            fails++;
            $error("FAIL reset_mid_mem observed=%h expected=%h", {State, Mreq, Wmem}, 5'b0);
        end
        Mrdy = 1'b0;
        @(negedge Clk);
        Clrn = 1'b1;
        do_ins(3, 1'b0, 0, 0);

        // randomized instruction stream
        repeat (150) begin
            r = $urandom_range(0, 19);
            lat_a = (r < 16) ? (r % 4) : (13 + (r - 16));
            r = $urandom_range(0, 19);
            lat_b = (r < 16) ? (r % 4) : (13 + (r - 16));
            do_ins($urandom_range(0, 15), 1'($urandom_range(0, 1)), lat_a, lat_b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
